// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes rx_in, qualifies the start bit, strobes each
// centred data bit out to an external SIPO register and checks the stop bit.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic enable,
  output logic shift,
  output logic shift_bit,
  output logic busy,
  output logic rx_done,
  output logic frame_err
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic             rx_m, rx_s;
  logic             shift_n, shift_bit_n, busy_n, rx_done_n, frame_err_n;

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= 1'b0;
      shift_bit <= 1'b0;
      busy      <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      shift_bit <= shift_bit_n;
      busy      <= busy_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = 1'b0;
    shift_bit_n = shift_bit;
    rx_done_n   = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (enable && !rx_s) state_n = S_START;
      end
      S_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n       = '0;
          shift_n     = 1'b1;
          shift_bit_n = rx_s;
          if (bit_idx == IDX_LAST) state_n = S_STOP;
          else bit_idx_n = bit_idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            rx_done_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it is not taken as a new start bit.
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame table plus hand-written corner sequences, with a
// scoreboard of expected strobes/pulses matched against events seen on the outputs.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int NBITS = 8;

  localparam int EV_SHIFT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_BOTH  = 3;

  logic clk, reset, rx_in, enable;
  logic shift, shift_bit, busy, rx_done, frame_err;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(NBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .enable    (enable),
    .shift     (shift),
    .shift_bit (shift_bit),
    .busy      (busy),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   kind;
    logic bitv;
    int   gap;
  } exp_t;

  typedef struct {
    int   kind;
    logic bitv;
    int   cyc;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       en;
    int         exp_strobes;
    int         exp_done;
    int         exp_err;
    int         exp_rises;
  } vec_t;

  exp_t sb_q[$];
  obs_t obs_q[$];

  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  // Monitor-owned counters and event log.
  int   cyc = 0;
  int   n_shift = 0, n_done = 0, n_err = 0, n_rise = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (rx_done && frame_err) obs_q.push_back('{EV_BOTH, 1'b0, cyc});
      else begin
        if (rx_done) begin n_done++; obs_q.push_back('{EV_DONE, 1'b0, cyc}); end
        if (frame_err) begin n_err++; obs_q.push_back('{EV_ERR, 1'b0, cyc}); end
      end
      if (shift) begin n_shift++; obs_q.push_back('{EV_SHIFT, shift_bit, cyc}); end
      if (busy && !busy_q) n_rise++;
    end
    busy_q = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic stop, input int nbits, input bit with_end);
    for (int i = 0; i < nbits; i++) sb_q.push_back('{EV_SHIFT, d[i], (i == 0) ? 0 : CPB});
    if (with_end) sb_q.push_back('{stop ? EV_DONE : EV_ERR, 1'b0, CPB});
  endtask

  // Match observed output events against the scoreboard, including spacing.
  task automatic drain();
    obs_t o;
    exp_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: event kind %0d bit %0d at cycle %0d, expected none", o.kind, o.bitv, o.cyc);
        continue;
      end
      e = sb_q.pop_front();
      if (o.kind != e.kind || (o.kind == EV_SHIFT && o.bitv !== e.bitv)) begin
        errors++;
        $display("FAIL sb_event: got kind %0d bit %0d, expected kind %0d bit %0d (cycle %0d)",
                 o.kind, o.bitv, e.kind, e.bitv, o.cyc);
      end
      if (e.gap != 0) check("sb_spacing", 32'(o.cyc - last_cyc), 32'(e.gap));
      last_cyc = o.cyc;
    end
  endtask

  // Drive one 10-bit frame; can raise enable at a given cycle or stop after N strobes.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push,
                            input int abort_after, input int en_at, output bit aborted);
    logic [9:0] bits;
    int base;
    bits    = {stop, d, 1'b0};
    base    = n_shift;
    aborted = 1'b0;
    if (push) push_frame(d, stop, NBITS, 1'b1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx_in = bits[b];
        if (b * CPB + c == en_at) enable = 1'b1;
        #1;
        if (abort_after > 0 && n_shift >= base + abort_after) begin
          aborted = 1'b1;
          return;
        end
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    bit ab;
    int s0, d0, e0, r0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8, 1, 0, 1};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 8, 1, 0, 1};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 0, 0, 0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8, 0, 1, 1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 8, 1, 0, 1};

    reset  = 1'b1;
    rx_in  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_shift", 32'(shift), 0);
    check("rst_shift_bit", 32'(shift_bit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_done", 32'(rx_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Frame table: data, stop bit, enable, expected strobe/done/err/busy-rise counts.
    foreach (vecs[i]) begin
      s0 = n_shift; d0 = n_done; e0 = n_err; r0 = n_rise;
      enable = vecs[i].en;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].en, 0, -1, ab);
      if (!vecs[i].stop) begin
        repeat (40) @(negedge clk);
        #1;
        check("break_busy_held", 32'(busy), 1);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("break_busy_released", 32'(busy), 0);
      end
      repeat (40) @(negedge clk);
      #1;
      check("vec_strobes", 32'(n_shift - s0), 32'(vecs[i].exp_strobes));
      check("vec_done", 32'(n_done - d0), 32'(vecs[i].exp_done));
      check("vec_err", 32'(n_err - e0), 32'(vecs[i].exp_err));
      check("vec_busy_rises", 32'(n_rise - r0), 32'(vecs[i].exp_rises));
      enable = 1'b1;
      drain();
    end

    // Short low glitch: START must abort at the half-bit check.
    s0 = n_shift; d0 = n_done; e0 = n_err; r0 = n_rise;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("glitch_strobes", 32'(n_shift - s0), 0);
    check("glitch_pulses", 32'((n_done - d0) + (n_err - e0)), 0);
    check("glitch_busy_rise", 32'(n_rise - r0), 1);
    check("glitch_busy_low", 32'(busy), 0);
    drain();

    // Reset after the third strobe of 0xFF, then receive 0x01 cleanly.
    push_frame(8'hFF, 1'b1, 3, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 3, -1, ab);
    check("abort_reached_3rd_strobe", 32'(ab), 1);
    reset = 1'b1;
    #1;
    check("midrst_shift", 32'(shift), 0);
    check("midrst_shift_bit", 32'(shift_bit), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pulses", 32'(rx_done | frame_err), 0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    s0 = n_shift;
    repeat (60) @(negedge clk);
    #1;
    check("midrst_no_more_strobes", 32'(n_shift - s0), 0);
    drain();
    d0 = n_done;
    send_frame(8'h01, 1'b1, 1'b1, 0, -1, ab);
    repeat (20) @(negedge clk);
    #1;
    check("post_reset_done", 32'(n_done - d0), 1);
    drain();

    // Back-to-back frames with no idle gap.
    s0 = n_shift; d0 = n_done; e0 = n_err;
    send_frame(8'h00, 1'b1, 1'b1, 0, -1, ab);
    send_frame(8'hFF, 1'b1, 1'b1, 0, -1, ab);
    repeat (20) @(negedge clk);
    #1;
    check("b2b_strobes", 32'(n_shift - s0), 16);
    check("b2b_done", 32'(n_done - d0), 2);
    check("b2b_err", 32'(n_err - e0), 0);
    drain();

    // Enable raised late in the last data bit (low): the short low tail is rejected.
    s0 = n_shift; d0 = n_done; e0 = n_err;
    enable = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 0, 8 * CPB + 12, ab);
    repeat (20) @(negedge clk);
    #1;
    check("late_en_strobes", 32'(n_shift - s0), 0);
    check("late_en_pulses", 32'((n_done - d0) + (n_err - e0)), 0);
    check("late_en_idle", 32'(busy), 0);
    drain();
    d0 = n_done;
    send_frame(8'h55, 1'b1, 1'b1, 0, -1, ab);
    repeat (20) @(negedge clk);
    #1;
    check("late_en_next_frame", 32'(n_done - d0), 1);
    drain();

    check("sb_leftover", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
